// File: rtl/dvi_framebuffer_controller.sv
// XGA raster timing and 3-stage pixel pipeline for a CH7301C DVI transmitter.
// A synchronous-read framebuffer is scanned in raster order and driven out over the 12-bit dual-edge bus.
module dvi_framebuffer_controller #(
    parameter logic        sync_polarity = 1'b0,
    parameter int unsigned RAM_width     = 1,
    parameter int unsigned RAM_depth     = 786432,
    parameter int unsigned h_active      = 1024,
    parameter int unsigned h_front       = 24,
    parameter int unsigned h_sync        = 136,
    parameter int unsigned h_back        = 160,
    parameter int unsigned v_active      = 768,
    parameter int unsigned v_front       = 3,
    parameter int unsigned v_sync        = 6,
    parameter int unsigned v_back        = 29
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [$clog2(RAM_depth)-1:0] framebuffer_addr,
    input  logic [RAM_width-1:0]         framebuffer_data,
    output logic [11:0]                  dvi_data,
    output logic                         dvi_de,
    output logic                         dvi_h,
    output logic                         dvi_v,
    output logic                         dvi_reset_b,
    output logic                         dvi_xclk_p,
    output logic                         dvi_xclk_n
);

    localparam int unsigned AW           = $clog2(RAM_depth);
    localparam int unsigned h_total      = h_active + h_front + h_sync + h_back;
    localparam int unsigned v_total      = v_active + v_front + v_sync + v_back;
    localparam int unsigned HW           = $clog2(h_total);
    localparam int unsigned VW           = $clog2(v_total);
    localparam int unsigned h_sync_start = h_active + h_front;
    localparam int unsigned h_sync_end   = h_sync_start + h_sync;
    localparam int unsigned v_sync_start = v_active + v_front;
    localparam int unsigned v_sync_end   = v_sync_start + v_sync;
    localparam logic        sync_idle    = ~sync_polarity;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active_c, hs_c, vs_c;
    logic [AW-1:0] addr_c;
    logic          de0, h0, v0;
    logic          de1, h1, v1;
    logic [23:0]   ram_pixel, pixel;
    logic [11:0]   word_a, word_b;

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(h_total - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(v_total - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        active_c = (h_cnt < HW'(h_active)) && (v_cnt < VW'(v_active));
        hs_c     = (h_cnt >= HW'(h_sync_start)) && (h_cnt < HW'(h_sync_end));
        vs_c     = (v_cnt >= VW'(v_sync_start)) && (v_cnt < VW'(v_sync_end));
        addr_c   = AW'(v_cnt) * AW'(h_active) + AW'(h_cnt);
    end

    // Stage 0: address to the RAM plus the timing flags that must travel with it
    always_ff @(posedge clk) begin
        if (!rst) begin
            framebuffer_addr <= '0;
            de0              <= 1'b0;
            h0               <= sync_idle;
            v0               <= sync_idle;
        end else begin
            framebuffer_addr <= active_c ? addr_c : '0;
            de0              <= active_c;
            h0               <= hs_c ? sync_polarity : sync_idle;
            v0               <= vs_c ? sync_polarity : sync_idle;
        end
    end

    // Stage 1: flags wait out the RAM read latency
    always_ff @(posedge clk) begin
        if (!rst) begin
            de1 <= 1'b0;
            h1  <= sync_idle;
            v1  <= sync_idle;
        end else begin
            de1 <= de0;
            h1  <= h0;
            v1  <= v0;
        end
    end

    if (RAM_width == 1) begin : g_mono
        assign ram_pixel = {24{framebuffer_data[0]}};
    end else begin : g_rgb
        assign ram_pixel = framebuffer_data[23:0];
    end

    assign pixel = de1 ? ram_pixel : '0;

    // Stage 2: pins; word A = {G[3:0],B}, word B = {R,G[7:4]}
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_a <= '0;
            word_b <= '0;
            dvi_de <= 1'b0;
            dvi_h  <= sync_idle;
            dvi_v  <= sync_idle;
        end else begin
            word_a <= pixel[11:0];
            word_b <= pixel[23:12];
            dvi_de <= de1;
            dvi_h  <= h1;
            dvi_v  <= v1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) dvi_reset_b <= 1'b0;
        else      dvi_reset_b <= 1'b1;
    end

    // ODDR-style output: word A during the high half of clk, word B during the low half
    always_comb dvi_data = clk ? word_a : word_b;

    assign dvi_xclk_p = clk;
    assign dvi_xclk_n = ~clk;

endmodule

// File: tb/tb_dvi_framebuffer_controller.sv
// Bench for dvi_framebuffer_controller on a scaled raster (32x20 total, 16x12 active).
// Mono/active-low and colour/active-high instances are checked against a raster-position model.
module tb_dvi_framebuffer_controller;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 12, VF = 2, VS = 3, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int DEPTH = HA * VA;
    localparam int NT = 18;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [7:0]  addr_m, addr_c;
    logic [0:0]  fb_m;
    logic [23:0] fb_c;
    logic [11:0] data_m, data_c;
    logic de_m, h_m, v_m, rb_m, xp_m, xn_m;
    logic de_c, h_c, v_c, rb_c, xp_c, xn_c;

    logic        mem_m [DEPTH];
    logic [23:0] mem_c [DEPTH];

    dvi_framebuffer_controller #(
        .sync_polarity(1'b0), .RAM_width(1), .RAM_depth(DEPTH),
        .h_active(HA), .h_front(HF), .h_sync(HS), .h_back(HB),
        .v_active(VA), .v_front(VF), .v_sync(VS), .v_back(VB)
    ) dut_m (
        .clk(clk), .rst(rst), .framebuffer_addr(addr_m), .framebuffer_data(fb_m),
        .dvi_data(data_m), .dvi_de(de_m), .dvi_h(h_m), .dvi_v(v_m),
        .dvi_reset_b(rb_m), .dvi_xclk_p(xp_m), .dvi_xclk_n(xn_m)
    );

    dvi_framebuffer_controller #(
        .sync_polarity(1'b1), .RAM_width(24), .RAM_depth(DEPTH),
        .h_active(HA), .h_front(HF), .h_sync(HS), .h_back(HB),
        .v_active(VA), .v_front(VF), .v_sync(VS), .v_back(VB)
    ) dut_c (
        .clk(clk), .rst(rst), .framebuffer_addr(addr_c), .framebuffer_data(fb_c),
        .dvi_data(data_c), .dvi_de(de_c), .dvi_h(h_c), .dvi_v(v_c),
        .dvi_reset_b(rb_c), .dvi_xclk_p(xp_c), .dvi_xclk_n(xn_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        fb_m <= mem_m[int'(addr_m)];
        fb_c <= mem_c[int'(addr_c)];
    end

    typedef struct {
        int          n;
        logic        de;
        logic        hs;
        logic        vs;
        logic [7:0]  addr;
        logic [11:0] wa;
        logic [11:0] wb;
    } vec_t;

    vec_t tbl [NT];

    int tests = 0;
    int fails = 0;
    int n = 0;
    int cyc = 0;
    int ti = 0;
    bit chk_en = 0;
    bit tbl_on = 0;
    bit meas_on = 0;
    int cnt_de_m = 0, cnt_hlo_m = 0, cnt_vlo_m = 0, cnt_hhi_c = 0, cnt_vhi_c = 0;
    logic prev_de = 1'b0, prev_h = 1'b1;
    int dq[$];
    int hq[$];

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d n=%0d got=%h want=%h", name, cyc, n, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Expected pins after the n-th clock edge with rst high (n=0: in reset)
    function automatic logic [35:0] model(input bit color, input int nn);
        logic        idle, de, hs, vs, rb;
        logic [7:0]  addr;
        logic [23:0] px;
        int p, h, v;
        idle = color ? 1'b0 : 1'b1;
        de = 1'b0; hs = idle; vs = idle; addr = 8'h00; px = 24'h0;
        rb = (nn >= 1);
        if (nn >= 1) begin
            p = (nn - 1) % FRAME; h = p % HT; v = p / HT;
            if (h < HA && v < VA) addr = 8'(v * HA + h);
        end
        if (nn >= 3) begin
            p = (nn - 3) % FRAME; h = p % HT; v = p / HT;
            de = (h < HA && v < VA);
            if (h >= HA + HF && h < HA + HF + HS) hs = ~idle;
            if (v >= VA + VF && v < VA + VF + VS) vs = ~idle;
            if (de) px = color ? mem_c[v * HA + h] : (mem_m[v * HA + h] ? 24'hFFFFFF : 24'h000000);
        end
        return {rb, de, hs, vs, addr, px[11:0], px[23:12]};
    endfunction

    task automatic step(input logic r);
        logic [35:0] got_m, got_c;
        rst = r;
        @(posedge clk);
        cyc++;
        n = r ? n + 1 : 0;
        #1;
        got_m = {rb_m, de_m, h_m, v_m, addr_m, data_m, 12'h000};
        got_c = {rb_c, de_c, h_c, v_c, addr_c, data_c, 12'h000};
        @(negedge clk);
        #1;
        got_m[11:0] = data_m;
        got_c[11:0] = data_c;
        if (chk_en) begin
            check("mono_pins", got_m, model(1'b0, n));
            check("color_pins", got_c, model(1'b1, n));
            if (tbl_on && ti < NT && tbl[ti].n == n) begin
                check($sformatf("vec%0d", ti), got_m,
                      {1'b1, tbl[ti].de, tbl[ti].hs, tbl[ti].vs, tbl[ti].addr, tbl[ti].wa, tbl[ti].wb});
                ti++;
            end
            if (meas_on) begin
                cnt_de_m  += int'(got_m[34]);
                cnt_hlo_m += int'(!got_m[33]);
                cnt_vlo_m += int'(!got_m[32]);
                cnt_hhi_c += int'(got_c[33]);
                cnt_vhi_c += int'(got_c[32]);
            end
            if (got_m[34] && !prev_de) dq.push_back(cyc);
            if (!got_m[33] && prev_h) hq.push_back(cyc);
        end
        prev_de = got_m[34];
        prev_h  = got_m[33];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel_cyc;
        bit found;

        // Bars: pairs of rows alternate white/black; colour RAM is random
        for (int a = 0; a < DEPTH; a++) begin
            mem_m[a] = (((a / HA) / 2) % 2) == 0;
            mem_c[a] = 24'($urandom);
        end

        //          n    de    hs    vs    addr    wa       wb
        tbl[0]  = '{1,   1'b0, 1'b1, 1'b1, 8'd0,   12'h000, 12'h000};
        tbl[1]  = '{2,   1'b0, 1'b1, 1'b1, 8'd1,   12'h000, 12'h000};
        tbl[2]  = '{3,   1'b1, 1'b1, 1'b1, 8'd2,   12'hFFF, 12'hFFF};
        tbl[3]  = '{18,  1'b1, 1'b1, 1'b1, 8'd0,   12'hFFF, 12'hFFF};
        tbl[4]  = '{19,  1'b0, 1'b1, 1'b1, 8'd0,   12'h000, 12'h000};
        tbl[5]  = '{23,  1'b0, 1'b0, 1'b1, 8'd0,   12'h000, 12'h000};
        tbl[6]  = '{28,  1'b0, 1'b0, 1'b1, 8'd0,   12'h000, 12'h000};
        tbl[7]  = '{29,  1'b0, 1'b1, 1'b1, 8'd0,   12'h000, 12'h000};
        tbl[8]  = '{33,  1'b0, 1'b1, 1'b1, 8'd16,  12'h000, 12'h000};
        tbl[9]  = '{35,  1'b1, 1'b1, 1'b1, 8'd18,  12'hFFF, 12'hFFF};
        tbl[10] = '{67,  1'b1, 1'b1, 1'b1, 8'd34,  12'h000, 12'h000};
        tbl[11] = '{136, 1'b1, 1'b1, 1'b1, 8'd71,  12'hFFF, 12'hFFF};
        tbl[12] = '{368, 1'b1, 1'b1, 1'b1, 8'd191, 12'h000, 12'h000};
        tbl[13] = '{370, 1'b1, 1'b1, 1'b1, 8'd0,   12'h000, 12'h000};
        tbl[14] = '{451, 1'b0, 1'b1, 1'b0, 8'd0,   12'h000, 12'h000};
        tbl[15] = '{535, 1'b0, 1'b0, 1'b0, 8'd0,   12'h000, 12'h000};
        tbl[16] = '{547, 1'b0, 1'b1, 1'b1, 8'd0,   12'h000, 12'h000};
        tbl[17] = '{643, 1'b1, 1'b1, 1'b1, 8'd2,   12'hFFF, 12'hFFF};

        // Power-on reset: let the first edges clear the X state, then hold 20 clk
        step(1'b0);
        step(1'b0);
        chk_en = 1;
        for (int k = 0; k < 20; k++) step(1'b0);

        // Release and run two full frames plus margin
        tbl_on = 1;
        dq.delete();
        hq.delete();
        for (int k = 0; k < 2 * FRAME + 20; k++) begin
            meas_on = (n >= 10 && n < 10 + 2 * FRAME);
            step(1'b1);
        end
        meas_on = 0;
        tbl_on = 0;
        check_int("table_consumed", ti, NT);

        check_int("de_clk_2frames", cnt_de_m, 2 * VA * HA);
        check_int("hsync_low_2frames", cnt_hlo_m, 2 * VT * HS);
        check_int("vsync_low_2frames", cnt_vlo_m, 2 * VS * HT);
        check_int("hsync_high_pol1", cnt_hhi_c, 2 * VT * HS);
        check_int("vsync_high_pol1", cnt_vhi_c, 2 * VS * HT);
        if (hq.size() >= 3) begin
            check_int("line_period_0", hq[1] - hq[0], HT);
            check_int("line_period_1", hq[2] - hq[1], HT);
        end else check_int("hsync_edges_seen", hq.size(), 3);
        if (dq.size() >= 13) begin
            check_int("de_line_period", dq[1] - dq[0], HT);
            check_int("de_frame_period", dq[12] - dq[0], FRAME);
        end else check_int("de_edges_seen", dq.size(), 13);

        // Mid-line reset on row 5, then restart from (0,0)
        found = 0;
        for (int k = 0; k < FRAME + 10 && !found; k++) begin
            step(1'b1);
            if (((n - 3) % FRAME) == 5 * HT + 8) found = 1;
        end
        check_int("found_row5", int'(found), 1);
        for (int k = 0; k < 4; k++) step(1'b0);
        dq.delete();
        rel_cyc = cyc + 1;
        for (int k = 0; k < FRAME + 40; k++) step(1'b1);
        if (dq.size() >= 13) begin
            check_int("de_after_reset_latency", dq[0] - rel_cyc, 2);
            check_int("frame_after_reset", dq[12] - dq[0], FRAME);
        end else check_int("de_edges_after_reset", dq.size(), 13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
